// File: rtl/aplic_irq_frontend.sv
// Interrupt source front end: synchronizes raw pins, optionally debounces them,
// applies the per-source polarity mode and produces registered level and edge pulses.
module aplic_irq_frontend #(
  parameter int unsigned NR_SRC      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                   i_clk,
  input  logic                   ni_rst,
  input  logic [NR_SRC-1:0]      i_irq_sources,
  input  logic [NR_SRC-1:0][2:0] i_sourcecfg,
  input  logic [NR_SRC-1:0]      i_filter_en,
  output logic [NR_SRC-1:0]      o_irq_level,
  output logic [NR_SRC-1:0]      o_irq_edge,
  output logic                   o_active
);

  localparam int unsigned CNT_W = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("aplic_irq_frontend: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_chk_filt
    $error("aplic_irq_frontend: FILTER_LEN must be >= 1");
  end

  logic [SYNC_STAGES-1:0][NR_SRC-1:0] sync_q;
  logic [NR_SRC-1:0]                  samp;
  logic [NR_SRC-1:0]                  filt_q, filt_d;
  logic [NR_SRC-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NR_SRC-1:0][2:0]             cfg_q;
  logic [NR_SRC-1:0]                  rect;
  logic [NR_SRC-1:0]                  level_q;
  logic [NR_SRC-1:0]                  edge_q, edge_d;

  assign samp = sync_q[SYNC_STAGES-1];

  // Debounce: a mismatch must be seen on FILTER_LEN consecutive samples to commit.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      if (!i_filter_en[i]) begin
        filt_d[i] = samp[i];
        cnt_d[i]  = '0;
      end else if (samp[i] == filt_q[i]) begin
        cnt_d[i]  = '0;
      end else if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
        filt_d[i] = samp[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Polarity rectification and edge detect; a cfg change cycle never emits an edge.
  always_comb begin
    rect   = '0;
    edge_d = '0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      case (i_sourcecfg[i])
        3'd4, 3'd6: rect[i] = filt_q[i];
        3'd5, 3'd7: rect[i] = ~filt_q[i];
        default:    rect[i] = 1'b0;
      endcase
      edge_d[i] = ((i_sourcecfg[i] == 3'd4) || (i_sourcecfg[i] == 3'd5)) &&
                  rect[i] && !level_q[i] && (i_sourcecfg[i] == cfg_q[i]);
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      sync_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      level_q <= '0;
      edge_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_irq_sources};
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      cfg_q   <= i_sourcecfg;
      level_q <= rect;
      edge_q  <= edge_d;
    end
  end

  assign o_irq_level = level_q;
  assign o_irq_edge  = edge_q;
  assign o_active    = |level_q;

endmodule

// File: doc/aplic_irq_frontend.md
APLIC_IRQ_FRONTEND -- requirements
Module: aplic_irq_frontend

Interface
REQ-001 SHALL have parameter NR_SRC, default 32, number of interrupt source lines.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; elaboration error if < 2.
REQ-003 SHALL have parameter FILTER_LEN, default 4, debounce length in cycles; elaboration error if < 1.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port ni_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_irq_sources  input  NR_SRC  raw asynchronous source pins.
REQ-007 SHALL have port i_sourcecfg  input  NR_SRC x 3  per-source mode: 0 inactive, 1 detached, 4 Edge1, 5 Edge0, 6 Level1, 7 Level0; 2/3 reserved.
REQ-008 SHALL have port i_filter_en  input  NR_SRC  per-source debounce enable.
REQ-009 SHALL have port o_irq_level  output  NR_SRC  registered rectified source value.
REQ-010 SHALL have port o_irq_edge  output  NR_SRC  one-cycle pulse on rectified rising edge, edge modes only.
REQ-011 SHALL have port o_active  output  1  OR-reduction of o_irq_level.

Function
REQ-012 SHALL pass each pin through a SYNC_STAGES-deep flop chain; s[i] = last stage.
REQ-013 SHALL keep per-source filtered bit f[i] and counter c[i], width $clog2(FILTER_LEN+1).
REQ-014 Filter disabled: f[i] <= s[i] every cycle; c[i] <= 0.
REQ-015 Filter enabled, s[i] == f[i]: c[i] <= 0, f[i] held.
REQ-016 Filter enabled, s[i] != f[i], c[i] < FILTER_LEN-1: c[i] <= c[i]+1.
REQ-017 Filter enabled, s[i] != f[i], c[i] == FILTER_LEN-1: f[i] <= s[i], c[i] <= 0; mismatch must persist FILTER_LEN consecutive cycles.
REQ-018 A single matching sample SHALL restart the count (no accumulation across glitches); c[i] never exceeds FILTER_LEN-1.
REQ-019 Toggling i_filter_en mid-count SHALL apply the new rule next edge; disable clears c[i].
REQ-020 Rectified r[i] (combinational): f[i] for modes 4/6, ~f[i] for modes 5/7, 0 for modes 0,1,2,3.
REQ-021 SHALL register o_irq_level[i] <= r[i] and cfg_q[i] <= i_sourcecfg[i] every cycle.
REQ-022 o_irq_edge[i] <= 1 iff mode in {4,5} AND r[i]==1 AND o_irq_level[i]==0 AND i_sourcecfg[i]==cfg_q[i]; else 0.
REQ-023 Cycle where i_sourcecfg[i] differs from cfg_q[i] SHALL produce no edge pulse (mode-change suppression); o_irq_level still updates.
REQ-024 Pin-to-o_irq_level latency: SYNC_STAGES+2 edges unfiltered; SYNC_STAGES+FILTER_LEN+1 edges filtered (FILTER_LEN=1 equals unfiltered).
REQ-025 o_irq_edge SHALL rise on same edge as o_irq_level; held rectified high yields exactly one pulse.
REQ-026 Sources SHALL be fully independent; simultaneous events on all NR_SRC lines handled same cycle.
REQ-027 o_active SHALL be combinational OR of o_irq_level, no extra latency.

Reset
REQ-028 ni_rst low SHALL asynchronously clear sync chain, f, c, cfg_q, o_irq_level, o_irq_edge; o_active = 0.
REQ-029 After reset release, first edge SHALL load cfg_q; any cfg != 0 gives mismatch, so no o_irq_edge on first cycle (Edge0 with pin low produces no spurious pulse).
REQ-030 Reset asserted mid-filter-count SHALL discard the count; counting restarts from 0 after release.

Verification
REQ-031 SYNC_STAGES=2, filter off, mode 4, pin 0->1 before edge 1 -> o_irq_level=1 and o_irq_edge=1 at edge 4, o_irq_edge=0 at edge 5.
REQ-032 FILTER_LEN=4, filter on, mode 6, pin high 3 cycles, low 1, high 4 -> f never toggles on 3-cycle pulse; o_irq_level rises 7 edges after 4-cycle run starts.
REQ-033 Mode 7, pin held low through reset release -> o_irq_level=1 at edge 1, o_irq_edge stays 0.
REQ-034 Mode 5, pin low; switch cfg to 4 with pin high -> o_irq_level stays 1 across switch, no o_irq_edge in mismatch cycle; later pin 0->1 in mode 4 gives one pulse.
REQ-035 NR_SRC=32, all pins toggle same cycle, mixed modes 0/4/6 -> mode 0 sources stay 0; modes 4/6 rise together; edge pulses only on mode 4 bits; o_active=1.
REQ-036 ni_rst pulsed low with c=2 of FILTER_LEN=4 -> all outputs 0 immediately; post-release pin high needs full 4-cycle run before f changes.
